pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central sequencing controller for the 5-stage CPU pipeline. Generates the per-stage advance and flush controls for the pipeline latches, including the EX/MEM latch.
- Detects load-use hazards between ID and EX.
- Applies branch flushes.
- Freezes the pipeline on memory wait.
- Runs the end-of-program drain when the finish instruction (all ones) reaches ID, then raises a sticky done.
- Provides cycle and stall counters for performance reporting.

Parameters:
DRAIN_DEPTH, 3, cycles spent in DRAIN after finish is detected in ID (ID→EX→MEM→WB); legal range 1..15
CNT_W, 32, width of cycle_count and stall_count

Ports:
CLOCK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE
mem_busy  in  1  data memory not ready; freeze entire pipeline
branch_taken  in  1  branch resolved taken in EX this cycle
id_instr  in  32  instruction in ID stage
ex_instr  in  32  instruction in EX stage
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID latch loads NOP
idex_flush  out  1  ID/EX latch loads NOP (bubble)
exmem_en  out  1  EX/MEM latch enable
memwb_en  out  1  MEM/WB latch enable
done  out  1  sticky; program finished and drained
cycle_count  out  CNT_W  cycles spent in RUN+DRAIN, saturating
stall_count  out  CNT_W  load-use + mem_busy cycles, saturating

Behaviour:
- State register: IDLE, RUN, DRAIN, HALT. Reset state is IDLE.
- Reset values: state=IDLE, all outputs 0, both counters 0, drain counter 0.
- RESET_N low mid-operation: everything returns to reset values immediately (asynchronous).
- Stage-control outputs are combinational from state and inputs, with no added latency. Counters and done are registered, so they update on the edge after the qualifying cycle.

IDLE:
- All enables and flushes 0.
- start=1 → RUN on the next edge. start is ignored in every other state.

RUN: evaluate the following per cycle in strict priority order.
1. mem_busy=1: all enables 0, flushes 0; stall_count++.
2. branch_taken=1: pc_en=ifid_en=exmem_en=memwb_en=1, ifid_flush=1, idex_flush=1. Branch wins over finish and load-use in the same cycle, because the ID instruction is on the wrong path.
3. id_instr==32'hFFFFFFFF (finish): pc_en=0, ifid_en=0, exmem_en=memwb_en=1, idex_flush=0 so the finish word advances to EX. Load drain counter with DRAIN_DEPTH-1; go to DRAIN.
4. Load-use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stall_count++. Condition:
   - ex_instr[31:26]==6'b100011 (lw), and
   - ex_instr[20:16]!=0, and
   - ex_instr[20:16]==id_instr[25:21], or (id opcode is R-type 000000, sw 101011 or beq 000100, and ex_instr[20:16]==id_instr[20:16]).
5. Otherwise: pc_en=ifid_en=exmem_en=memwb_en=1, flushes 0.

DRAIN:
- pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
- branch_taken is ignored.
- mem_busy=1 freezes the pipeline as in RUN, and the drain counter holds. stall_count++.
- Otherwise the drain counter decrements. When it is 0 on a non-busy cycle, go to HALT.

HALT:
- All enables 0, flushes 0, done=1.
- Remains in HALT until reset.

Counters:
- cycle_count increments on every cycle in RUN or DRAIN, including busy cycles.
- Both counters saturate at all-ones and never wrap.

Decomposition:
- Package cpu_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - FINISH_INSTR = 32'hFFFFFFFF
  - state enum for pipe_ctrl
  - field-slice helpers rs/rt/opcode
- Sub-module hazard_detect (purely combinational): inputs id_instr, ex_instr; output load_use.
- pipe_ctrl contains the FSM, the priority logic and the counters.

Test Plan:
1. Reset, then start=1 with 10 independent add instructions: pc_en=1 for every cycle in RUN; cycle_count=10 after 10 cycles; stall_count=0.
2. ex_instr=lw $t0 (rt=8), id_instr=add using rs=8: for exactly 1 cycle pc_en=0, ifid_en=0, idex_flush=1; stall_count=1. Repeat with rt=0: no stall.
3. branch_taken=1 in the same cycle that id_instr=32'hFFFFFFFF and a load-use condition holds: ifid_flush=idex_flush=1, pc_en=1; state stays RUN; done remains 0.
4. Finish with DRAIN_DEPTH=3 and no busy cycles: 1 detection cycle + 3 DRAIN cycles, then done=1 and all enables 0. Insert mem_busy for 2 DRAIN cycles: done is delayed by exactly 2 cycles; stall_count=2.
5. Assert RESET_N low during DRAIN: all outputs 0 immediately; state IDLE; start then resumes normal RUN.
6. Force counters near all-ones (CNT_W=4): cycle_count saturates at 15 and does not wrap.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, finish word, controller states and instruction field helpers
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [31:0] FINISH_INSTR = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_e;
  function automatic logic [5:0] opcode(input logic [31:0] i);
    return i[31:26];
  endfunction
  function automatic logic [4:0] rs(input logic [31:0] i);
    return i[25:21];
  endfunction
  function automatic logic [4:0] rt(input logic [31:0] i);
    return i[20:16];
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags an ID instruction reading the register a load in EX is still fetching
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic [31:0] ex_instr,
  output logic        load_use
);
  logic rt_src;
  logic unused_bits;
  always_comb begin
    rt_src      = opcode(id_instr) inside {OP_RTYPE, OP_SW, OP_BEQ};
    load_use    = opcode(ex_instr) == OP_LW && rt(ex_instr) != 5'd0 &&
                  (rt(ex_instr) == rs(id_instr) || (rt_src && rt(ex_instr) == rt(id_instr)));
    unused_bits = ^{id_instr[15:0], ex_instr[25:21], ex_instr[15:0]};
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer producing stage advance/flush controls, drain-to-halt and perf counters
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             mem_busy,
  input  logic             branch_taken,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      ex_instr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);
  state_e state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic done_q;
  logic [CNT_W-1:0] cycle_q, stall_q;
  logic load_use, stall, active;

  hazard_detect u_hazard (
    .id_instr (id_instr),
    .ex_instr (ex_instr),
    .load_use (load_use)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en} = '0;
    stall   = 1'b0;
    active  = state_q == RUN || state_q == DRAIN;
    case (state_q)
      IDLE: state_d = start ? RUN : IDLE;
      RUN:
        if (mem_busy) stall = 1'b1;
        else if (branch_taken) {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en} = '1;
        else if (id_instr == FINISH_INSTR) begin
          {exmem_en, memwb_en} = 2'b11;
          drain_d = 4'(DRAIN_DEPTH - 1);
          state_d = DRAIN;
        end else if (load_use) begin
          {idex_flush, exmem_en, memwb_en} = 3'b111;
          stall = 1'b1;
        end else {pc_en, ifid_en, exmem_en, memwb_en} = 4'b1111;
      DRAIN:
        if (mem_busy) stall = 1'b1;
        else begin
          {idex_flush, exmem_en, memwb_en} = 3'b111;
          drain_d = drain_q - 4'(drain_q != 4'd0);
          state_d = drain_q == 4'd0 ? HALT : DRAIN;
        end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= state_d == HALT;
      cycle_q <= cycle_q + CNT_W'(active && cycle_q != '1);
      stall_q <= stall_q + CNT_W'(stall && stall_q != '1);
    end
  end

  assign done        = done_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus randomized episodes against a phase-level reference model
module tb_pipe_ctrl;
  localparam int DD = 3;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [5:0] OPS [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8};

  logic CLOCK = 0, RESET_N = 0, start = 0, mem_busy = 0, branch_taken = 0;
  logic [31:0] id_instr = 0, ex_instr = 0;
  logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en, done;
  logic [CW-1:0] cycle_count, stall_count;

  int vectors = 0, miscompares = 0;
  int phase = 0, drain_left = 0, cyc_m = 0, stl_m = 0;

  pipe_ctrl #(.DRAIN_DEPTH(DD), .CNT_W(CW)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .mem_busy(mem_busy),
    .branch_taken(branch_taken), .id_instr(id_instr), .ex_instr(ex_instr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .done(done),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit uses_load(input logic [31:0] id, input logic [31:0] ex);
    logic [5:0] iop;
    iop = id[31:26];
    if (ex[31:26] != 6'd35 || ex[20:16] == 5'd0) return 0;
    if (ex[20:16] == id[25:21]) return 1;
    return (iop == 6'd0 || iop == 6'd43 || iop == 6'd4) && ex[20:16] == id[20:16];
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    i = $urandom;
    i[31:26] = OPS[$urandom_range(0, 4)];
    i[25:21] = 5'($urandom_range(0, 3));
    i[20:16] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // phase: 0 idle, 1 running, 2 draining, 3 halted
  task automatic cyc(input bit st, input bit bz, input bit br, input logic [31:0] idi, input logic [31:0] exi);
    logic [5:0] e;
    bit fin, lu;
    @(negedge CLOCK);
    start = st; mem_busy = bz; branch_taken = br; id_instr = idi; ex_instr = exi;
    #1;
    fin = idi == 32'hFFFF_FFFF;
    lu  = uses_load(idi, exi);
    check("done", 32'(done), 32'(phase == 3));
    check("cycle_count", 32'(cycle_count), cyc_m);
    check("stall_count", 32'(stall_count), stl_m);
    e = 6'b0;
    if (phase == 1 && !bz) e = br ? 6'b111111 : fin ? 6'b000011 : lu ? 6'b000111 : 6'b110011;
    if (phase == 2 && !bz) e = 6'b000111;
    check("stage_ctl", 32'({pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en}), 32'(e));
    if ((phase == 1 || phase == 2) && cyc_m < SAT) cyc_m++;
    if (((phase == 1 || phase == 2) && bz) || (phase == 1 && !br && !fin && lu))
      if (stl_m < SAT) stl_m++;
    if (phase == 0 && st) phase = 1;
    else if (phase == 1 && !bz && !br && fin) begin
      phase = 2;
      drain_left = DD;
    end else if (phase == 2 && !bz) begin
      drain_left--;
      if (drain_left == 0) phase = 3;
    end
  endtask

  task automatic rst_mid();
    @(negedge CLOCK);
    #3;
    start = 0;
    RESET_N = 0;
    #1;
    check("rst_ctl", 32'({pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en}), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt", 32'({cycle_count, stall_count}), 0);
    phase = 0; drain_left = 0; cyc_m = 0; stl_m = 0;
    @(negedge CLOCK);
    RESET_N = 1;
  endtask

  logic [31:0] add_a, add_b, lw8, lw0, add8, add0, lw31;
  bit b_busy, b_br, b_st;
  logic [31:0] rid;

  initial begin
    add_a = {6'd0, 5'd1, 5'd2, 5'd3, 11'h20};
    add_b = {6'd0, 5'd4, 5'd5, 5'd6, 11'h20};
    lw8   = {6'd35, 5'd0, 5'd8, 16'h0};
    add8  = {6'd0, 5'd8, 5'd9, 5'd10, 11'h20};
    lw0   = {6'd35, 5'd0, 5'd0, 16'h0};
    add0  = {6'd0, 5'd0, 5'd9, 5'd10, 11'h20};
    lw31  = {6'd35, 5'd0, 5'd31, 16'h0};
    rst_mid();
    cyc(1, 0, 0, add_a, add_b);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, add_a, add_b);
    cyc(0, 0, 0, add8, lw8);
    cyc(0, 0, 0, add_a, add_b);
    cyc(0, 0, 0, add0, lw0);
    cyc(0, 0, 1, 32'hFFFF_FFFF, lw31);
    cyc(0, 0, 0, add_a, add_b);
    cyc(0, 0, 0, 32'hFFFF_FFFF, add_b);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, add_a, add_b);
    rst_mid();
    cyc(1, 0, 0, add_a, add_b);
    cyc(0, 0, 0, 32'hFFFF_FFFF, add_b);
    cyc(0, 0, 0, add_a, add_b);
    cyc(0, 1, 0, add_a, add_b);
    cyc(0, 1, 0, add_a, add_b);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, add_a, add_b);
    check("halt_stalls", 32'(stall_count), 2);
    rst_mid();
    cyc(1, 0, 0, add_a, add_b);
    cyc(0, 0, 0, 32'hFFFF_FFFF, add_b);
    cyc(0, 0, 0, add_a, add_b);
    rst_mid();
    cyc(1, 0, 0, add_a, add_b);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, add_a, add_b);
    check("cycle_sat", 32'(cycle_count), SAT);
    for (int ep = 0; ep < 25; ep++) begin
      rst_mid();
      cyc(1, 0, 0, rnd_instr(), rnd_instr());
      for (int n = 0; n < 80 && phase != 3; n++) begin
        b_busy = $urandom_range(0, 4) == 0;
        b_br   = $urandom_range(0, 6) == 0;
        b_st   = $urandom_range(0, 9) == 0;
        rid    = $urandom_range(0, 29) == 0 ? 32'hFFFF_FFFF : rnd_instr();
        cyc(b_st, b_busy, b_br, rid, rnd_instr());
      end
      for (int n = 0; n < 2; n++) cyc($urandom_range(0, 1) == 1, 0, 0, rnd_instr(), rnd_instr());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
